fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_if.sv | 11 +
 rtl/fetch_stage.sv | 140 ++++++++++++++
 tb/tb_fetch_stage.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// The fetch stage drives req/addr; imem answers with a one-cycle ack strobe plus data.
interface fetch_stage_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
   modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: single outstanding imem request, one-entry skid buffer for
// downstream stalls, and redirect flushing that discards responses already in flight.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 stall,
   input  logic                 redirect,
   input  logic [31:0]          redirect_PC,
   fetch_stage_if.master        imem,
   output logic [31:0]          PC_out,
   output logic [31:0]          PC_4_out,
   output logic [31:0]          instr_out,
   output logic                 nop_out
);

   typedef enum logic [1:0] {FETCH, HOLD, DROP} state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] pc_4;
      logic [31:0] instr;
      logic        nop;
   } out_t;

   localparam out_t BUBBLE = '{pc: 32'd0, pc_4: 32'd0, instr: 32'd0, nop: 1'b1};

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] fetch_addr_q, fetch_addr_d;
   logic        buf_valid_q, buf_valid_d;
   logic [31:0] buf_pc_q, buf_pc_d;
   logic [31:0] buf_instr_q, buf_instr_d;
   out_t        out_q, out_d;

   logic [31:0] target;
   logic [31:0] pc_plus4;
   logic [31:0] addr_plus4;

   assign target     = redirect_PC & ~32'd3;
   assign pc_plus4   = pc_q + 32'd4;
   assign addr_plus4 = fetch_addr_q + 32'd4;

   // A request is visible in FETCH and DROP; reset gates it off combinationally.
   assign imem.imem_req  = rst && (state_q != HOLD);
   assign imem.imem_addr = fetch_addr_q;

   assign PC_out    = out_q.pc;
   assign PC_4_out  = out_q.pc_4;
   assign instr_out = out_q.instr;
   assign nop_out   = out_q.nop;

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
      state_d      = state_q;
      pc_d         = pc_q;
      fetch_addr_d = fetch_addr_q;
      buf_valid_d  = buf_valid_q;
      buf_pc_d     = buf_pc_q;
      buf_instr_d  = buf_instr_q;
      out_d        = out_q;

      if (redirect) begin
         pc_d        = target;
         buf_valid_d = 1'b0;
         out_d       = BUBBLE;
         unique case (state_q)
            FETCH: begin
               if (imem.imem_ack) fetch_addr_d = target;
               else               state_d      = DROP;
            end
            HOLD: begin
               state_d      = FETCH;
               fetch_addr_d = target;
            end
            default: ;
         endcase
      end else begin
         unique case (state_q)
            FETCH: begin
               if (imem.imem_ack) begin
                  pc_d         = pc_plus4;
                  fetch_addr_d = pc_plus4;
                  if (stall) begin
                     buf_valid_d = 1'b1;
                     buf_pc_d    = fetch_addr_q;
                     buf_instr_d = imem.imem_rdata;
                     state_d     = HOLD;
                  end else begin
                     out_d = '{pc: fetch_addr_q, pc_4: addr_plus4,
                               instr: imem.imem_rdata, nop: 1'b0};
                  end
               end else if (!stall) begin
                  out_d = BUBBLE;
               end
            end
            HOLD: begin
               if (!stall) begin
                  out_d       = '{pc: buf_pc_q, pc_4: buf_pc_q + 32'd4,
                                  instr: buf_instr_q, nop: 1'b0};
                  buf_valid_d = 1'b0;
                  state_d     = FETCH;
               end
            end
            DROP: begin
               // The stale response is swallowed; resume from the latest redirect target.
               if (imem.imem_ack) begin
                  fetch_addr_d = pc_q;
                  state_d      = FETCH;
               end
               if (!stall) out_d = BUBBLE;
            end
            default: state_d = FETCH;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (!rst) begin
         state_q      <= FETCH;
         pc_q         <= RESET_PC & ~32'd3;
         fetch_addr_q <= RESET_PC & ~32'd3;
         buf_valid_q  <= 1'b0;
         buf_pc_q     <= 32'd0;
         buf_instr_q  <= 32'd0;
         out_q        <= BUBBLE;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         fetch_addr_q <= fetch_addr_d;
         buf_valid_q  <= buf_valid_d;
         buf_pc_q     <= buf_pc_d;
         buf_instr_q  <= buf_instr_d;
         out_q        <= out_d;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a randomized run; a scoreboard of the
// expected sequential instruction stream is compared whenever the pipeline consumes an output.
module tb_fetch_stage;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] WRAP_PC  = 32'hFFFF_FFF8;

   localparam int ACK_NONE  = 0;
   localparam int ACK_REQ   = 1;
   localparam int ACK_RAND  = 2;
   localparam int ACK_FORCE = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_PC;
   logic [31:0] PC_out, PC_4_out, instr_out;
   logic        nop_out;
   logic [31:0] w_pc, w_pc4, w_instr;
   logic        w_nop;

   int n_checks = 0;
   int n_fail   = 0;
   bit mon_en   = 1'b0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] model_pc;

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
   endfunction

   fetch_stage_if bus ();
   fetch_stage_if wrap_bus ();

   fetch_stage #(.RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_PC(redirect_PC),
      .imem(bus.master), .PC_out(PC_out), .PC_4_out(PC_4_out), .instr_out(instr_out),
      .nop_out(nop_out)
   );

   // Second instance near the top of the address space, zero-wait memory, never stalled.
   assign wrap_bus.imem_ack   = wrap_bus.imem_req;
   assign wrap_bus.imem_rdata = mem_word(wrap_bus.imem_addr);

   fetch_stage #(.RESET_PC(WRAP_PC)) dut_wrap (
      .clk(clk), .rst(rst), .stall(1'b0), .redirect(1'b0), .redirect_PC(32'd0),
      .imem(wrap_bus.master), .PC_out(w_pc), .PC_4_out(w_pc4), .instr_out(w_instr),
      .nop_out(w_nop)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // One clock cycle: drive control inputs, update the reference stream, then answer imem.
   task automatic step(input logic r, input logic s, input logic d,
                       input logic [31:0] tgt, input int mode);
      logic a;
      @(posedge clk);
      #1;
      rst         = r;
      stall       = s;
      redirect    = d;
      redirect_PC = tgt;
      if (!r) begin
         exp_q.delete();
         model_pc = RESET_PC;
      end else if (d) begin
         exp_q.delete();
         model_pc = tgt & ~32'd3;
      end
      while (exp_q.size() < 8) begin
         exp_q.push_back('{pc: model_pc, instr: mem_word(model_pc)});
         model_pc += 32'd4;
      end
      #1;
      case (mode)
         ACK_REQ:   a = bus.imem_req;
         ACK_RAND:  a = bus.imem_req && ($urandom_range(0, 1) == 1);
         ACK_FORCE: a = 1'b1;
         default:   a = 1'b0;
      endcase
      bus.imem_ack   = a;
      bus.imem_rdata = a ? mem_word(bus.imem_addr) : $urandom();
   endtask

   // Monitor: a valid output seen with stall=0 and no redirect is consumed by IF_ID.
   logic        prev_rst = 1'b0, prev_req = 1'b0, prev_ack = 1'b0;
   logic [31:0] prev_addr = 32'd0;

   always @(negedge clk) begin
      if (mon_en) begin
         if (!rst) begin
            check("req_in_reset", {31'd0, bus.imem_req}, 32'd0);
         end else begin
            if (bus.imem_req) check("addr_aligned", {30'd0, bus.imem_addr[1:0]}, 32'd0);
            if (prev_rst && prev_req && !prev_ack) begin
               check("req_held", {31'd0, bus.imem_req}, 32'd1);
               check("addr_held", bus.imem_addr, prev_addr);
            end
            if (nop_out) begin
               check("bubble_pc", PC_out, 32'd0);
               check("bubble_pc4", PC_4_out, 32'd0);
               check("bubble_instr", instr_out, 32'd0);
            end else if (!stall && !redirect) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL sb_empty: got pc 0x%08h, expected no delivery", PC_out);
               end else begin
                  exp_t e;
                  e = exp_q.pop_front();
                  check("sb_pc", PC_out, e.pc);
                  check("sb_pc4", PC_4_out, e.pc + 32'd4);
                  check("sb_instr", instr_out, e.instr);
               end
            end
         end
      end
      prev_rst  = mon_en && rst;
      prev_req  = bus.imem_req;
      prev_ack  = bus.imem_ack;
      prev_addr = bus.imem_addr;
   end

   initial begin
      rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_PC = 32'd0;
      bus.imem_ack = 1'b0; bus.imem_rdata = 32'd0;
      model_pc = RESET_PC;

      // Reset with a spurious ack that must be ignored.
      step(0, 0, 0, 0, ACK_FORCE);
      step(0, 0, 0, 0, ACK_FORCE);
      check("rst_nop", {31'd0, nop_out}, 32'd1);
      check("rst_pc", PC_out, 32'd0);
      check("rst_pc4", PC_4_out, 32'd0);
      check("rst_instr", instr_out, 32'd0);
      check("rst_req", {31'd0, bus.imem_req}, 32'd0);
      mon_en = 1'b1;

      // Zero-wait stream and wrap-around instance.
      step(1, 0, 0, 0, ACK_REQ);
      check("first_req", {31'd0, bus.imem_req}, 32'd1);
      check("first_addr", bus.imem_addr, RESET_PC);
      check("wrap_first_addr", wrap_bus.imem_addr, WRAP_PC);
      check("first_nop", {31'd0, nop_out}, 32'd1);
      step(1, 0, 0, 0, ACK_REQ);
      check("stream_pc0", PC_out, 32'h0);
      check("stream_nop0", {31'd0, nop_out}, 32'd0);
      check("stream_instr0", instr_out, mem_word(32'h0));
      check("stream_addr4", bus.imem_addr, 32'h4);
      check("wrap_pc0", w_pc, 32'hFFFF_FFF8);
      check("wrap_pc4_0", w_pc4, 32'hFFFF_FFFC);
      step(1, 0, 0, 0, ACK_REQ);
      check("stream_pc1", PC_out, 32'h4);
      check("stream_pc4_1", PC_4_out, 32'h8);
      check("wrap_pc1", w_pc, 32'hFFFF_FFFC);
      check("wrap_pc4_1", w_pc4, 32'h0000_0000);
      check("wrap_instr1", w_instr, mem_word(32'hFFFF_FFFC));
      step(1, 0, 0, 0, ACK_REQ);
      check("stream_pc2", PC_out, 32'h8);
      check("wrap_pc2", w_pc, 32'h0000_0000);
      check("wrap_nop2", {31'd0, w_nop}, 32'd0);

      // Stall with skid: ack for 0x10 lands while stalled.
      step(1, 1, 0, 0, ACK_REQ);
      check("skid_pc_c", PC_out, 32'hC);
      check("skid_addr10", bus.imem_addr, 32'h10);
      for (int i = 0; i < 2; i++) begin
         step(1, 1, 0, 0, ACK_REQ);
         check("hold_req", {31'd0, bus.imem_req}, 32'd0);
         check("hold_pc", PC_out, 32'hC);
      end
      step(1, 0, 0, 0, ACK_REQ);
      check("release_pc", PC_out, 32'hC);
      step(1, 0, 0, 0, ACK_NONE);
      check("skid_out10", PC_out, 32'h10);
      check("skid_req", {31'd0, bus.imem_req}, 32'd1);
      check("skid_addr14", bus.imem_addr, 32'h14);
      step(1, 0, 0, 0, ACK_REQ);
      check("no_ack_bubble", {31'd0, nop_out}, 32'd1);

      // Redirect while the request for 0x20 is pending.
      step(1, 0, 0, 0, ACK_REQ);
      step(1, 0, 0, 0, ACK_REQ);
      step(1, 0, 0, 0, ACK_NONE);
      check("pend_addr20", bus.imem_addr, 32'h20);
      step(1, 0, 1, 32'h100, ACK_NONE);
      step(1, 0, 0, 0, ACK_REQ);
      check("drop_addr", bus.imem_addr, 32'h20);
      check("drop_nop", {31'd0, nop_out}, 32'd1);
      step(1, 0, 0, 0, ACK_REQ);
      check("redir_addr100", bus.imem_addr, 32'h100);
      check("redir_nop", {31'd0, nop_out}, 32'd1);

      // Redirect with simultaneous ack and stall to an unaligned target.
      step(1, 1, 1, 32'h203, ACK_REQ);
      check("redir_out100", PC_out, 32'h100);
      step(1, 1, 0, 0, ACK_NONE);
      check("redir2_nop", {31'd0, nop_out}, 32'd1);
      check("redir2_instr", instr_out, 32'd0);
      check("redir2_req", {31'd0, bus.imem_req}, 32'd1);
      check("redir2_addr", bus.imem_addr, 32'h200);
      step(1, 0, 0, 0, ACK_REQ);
      check("redir2_still_nop", {31'd0, nop_out}, 32'd1);

      // Reset while holding a buffered instruction.
      step(1, 1, 0, 0, ACK_REQ);
      check("pre_hold_pc", PC_out, 32'h200);
      step(0, 1, 0, 0, ACK_FORCE);
      step(0, 1, 0, 0, ACK_FORCE);
      check("mid_rst_nop", {31'd0, nop_out}, 32'd1);
      check("mid_rst_pc", PC_out, 32'd0);
      check("mid_rst_pc4", PC_4_out, 32'd0);
      check("mid_rst_req", {31'd0, bus.imem_req}, 32'd0);
      step(1, 0, 0, 0, ACK_REQ);
      check("post_rst_req", {31'd0, bus.imem_req}, 32'd1);
      check("post_rst_addr", bus.imem_addr, RESET_PC);
      step(1, 0, 0, 0, ACK_REQ);
      check("post_rst_pc", PC_out, RESET_PC);

      // Randomized traffic; the monitor scores every consumed instruction.
      for (int i = 0; i < 4000; i++) begin
         logic        r, s, d;
         logic [31:0] t;
         r = ($urandom_range(0, 399) != 0);
         s = ($urandom_range(0, 9) < 3);
         d = ($urandom_range(0, 19) == 0);
         t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                         : $urandom();
         step(r, s, d, t, ACK_RAND);
      end
      step(1, 0, 0, 0, ACK_NONE);
      step(1, 0, 0, 0, ACK_NONE);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
